regs_write_port: RTL and testbench
==================================

# regs_write_port

Write-side front end of the integer register file. Merges the in-order pipeline writeback result with out-of-order results from multi-cycle units (divider, slow loads) onto the file's single write port, and buffers the multi-cycle results in a small FIFO. Keeps a busy scoreboard so decode can stall on registers whose multi-cycle result has not yet been written. Sits between the WB stage / multi-cycle units and the register file; the decode hazard logic drives its query ports.

## Interface
- DATA_WIDTH, 32, register data width
- REGS_WIDTH, 5, register address width (32 registers, x0 hardwired zero)
- DEPTH, 4, multi-cycle result FIFO depth; power of two, at least 2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous and active-low
- cpu_en  in  1  global enable from top module; 0 freezes all state
- wb_valid / wb_rd / wb_data  in  1 / REGS_WIDTH / DATA_WIDTH  pipeline WB result; no backpressure
- mc_issue / mc_issue_rd  in  1 / REGS_WIDTH  decode issued a multi-cycle op targeting mc_issue_rd
- mc_valid / mc_rd / mc_data  in  1 / REGS_WIDTH / DATA_WIDTH  multi-cycle result offer
- mc_ready  out  1  FIFO can accept; transfer when mc_valid & mc_ready
- rs1_address, rs2_address  in  REGS_WIDTH each  decode source queries
- rs1_busy, rs2_busy  out  1 each  combinational: queried register awaits a multi-cycle result
- is_write_regs / write_address / write_data  out  1 / REGS_WIDTH / DATA_WIDTH  registered drive to register file write port
- pending  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (rst==0 at posedge): FIFO empty, pointers 0, busy vector 0, is_write_regs=0, write_address=0, write_data=0, pending=0. mc_ready=0 while rst==0.
- cpu_en==0: FIFO, pointers, busy vector hold; is_write_regs register loads 0 (address/data hold). mc_ready=0. Offers are not consumed.
- Write arbitration per enabled cycle, fixed priority:
  - wb_valid & wb_rd!=0: output register loads {1, wb_rd, wb_data}; FIFO not popped.
  - else FIFO non-empty: pop head; output register loads {1, head_rd, head_data}.
  - else is_write_regs loads 0.
- wb_valid with wb_rd==0 is discarded and counts as no pipeline write (FIFO may drain that cycle).
- FIFO push on mc_valid & mc_ready with mc_rd!=0; mc_rd==0 results are accepted and dropped.
- mc_ready = rst & cpu_en & (pending != DEPTH). Full does not look ahead to a same-cycle pop.
- Simultaneous push and pop: both happen, pending unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Scoreboard: busy[31:1] registers, busy[0] constant 0.
  - Set busy[mc_issue_rd] on mc_issue & mc_issue_rd!=0.
  - Clear busy[head_rd] on pop.
  - Same register set and cleared in one cycle: set wins.
- rsN_busy = busy[rsN_address]; address 0 always returns 0.
- Decode never issues a multi-cycle op to an already-busy rd (WAW stall upstream); no result ordering beyond FIFO order.

## Timing
- Input to write port: 1 cycle. A WB result at posedge N appears on the outputs after posedge N; the register file commits it at the following negedge.
- A popped FIFO entry follows the same 1-cycle path. Its busy bit clears at the same posedge, so the busy deassertion and the register file write occur in the same cycle. The negedge write makes the data readable in the second half of that cycle.
- Worst-case FIFO residency is unbounded while wb_valid is continuous.
- mc_ready reasserts the cycle after a pop from full.
- Reset asserted mid-operation discards FIFO contents and busy bits at that posedge. No write is emitted after the reset edge.

## Test plan
- Reset: hold rst=0 2 cycles with mc_valid=1 -> mc_ready=0, is_write_regs=0, pending=0, rs1_busy=0 for any rs1_address.
- Pipeline only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> next cycle is_write_regs=1, write_address=5, write_data=0xDEADBEEF. wb_rd=0 -> is_write_regs=0.
- Scoreboard: mc_issue rd=7 -> rs1_address=7 gives rs1_busy=1. mc result rd=7 data=0x1234 with wb idle -> write of 0x1234 to x7 the next cycle and rs1_busy=0 in that same cycle.
- Priority/full: wb_valid held 1; push 4 mc results (rd 1..4) -> pending=4, mc_ready=0, no mc writes emitted. Drop wb_valid -> writes to x1,x2,x3,x4 in order on 4 consecutive cycles. mc_ready=1 after the first pop.
- Simultaneous push/pop at pending=2 -> pending stays 2. Wrap: 10 push/pop cycles keep the FIFO order intact.
- cpu_en=0 for 3 cycles with pending=2 -> no writes, pending=2, busy unchanged. Re-enable -> drain resumes. Also: set and clear of the same rd in one cycle leaves busy=1.

Source files
------------

// File: rtl/regs_write_port.sv
// Register file write-port front end: merges the WB result with buffered
// multi-cycle results and tracks registers still awaiting a multi-cycle write.

module regs_busy_bit (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_busy
);
    logic r_busy;

    // Set beats clear so a re-issue in the drain cycle stays tracked.
    always_ff @(posedge i_clk) begin
        if (!i_rst)     r_busy <= 1'b0;
        else if (i_set) r_busy <= 1'b1;
        else if (i_clr) r_busy <= 1'b0;
    end

    assign o_busy = r_busy;
endmodule

module regs_write_port #(
    parameter  int DATA_WIDTH = 32,
    parameter  int REGS_WIDTH = 5,
    parameter  int DEPTH      = 4,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = PW + 1,
    localparam int NREGS      = 1 << REGS_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_en,
    input  logic                  i_wb_valid,
    input  logic [REGS_WIDTH-1:0] i_wb_rd,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_mc_issue,
    input  logic [REGS_WIDTH-1:0] i_mc_issue_rd,
    input  logic                  i_mc_valid,
    input  logic [REGS_WIDTH-1:0] i_mc_rd,
    input  logic [DATA_WIDTH-1:0] i_mc_data,
    output logic                  o_mc_ready,
    input  logic [REGS_WIDTH-1:0] i_rs1_address,
    input  logic [REGS_WIDTH-1:0] i_rs2_address,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_is_write_regs,
    output logic [REGS_WIDTH-1:0] o_write_address,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic [CW-1:0]         o_pending
);
    typedef struct packed {
        logic [REGS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t             r_fifo [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_cnt;
    logic            r_is_write;
    wr_t             r_out;

    logic            w_wb_hit;
    logic            w_push;
    logic            w_pop;
    wr_t             w_head;
    logic [NREGS-1:0] w_busy;

    assign w_wb_hit   = i_wb_valid && (i_wb_rd != '0);
    assign o_mc_ready = i_rst && i_cpu_en && (r_cnt != CW'(DEPTH));
    // rd==0 results are handshaken but never stored.
    assign w_push     = o_mc_ready && i_mc_valid && (i_mc_rd != '0);
    assign w_pop      = i_rst && i_cpu_en && !w_wb_hit && (r_cnt != '0);
    assign w_head     = r_fifo[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wptr] <= '{rd: i_mc_rd, data: i_mc_data};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_cpu_en) begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_is_write <= 1'b0;
            r_out      <= '0;
        end else if (!i_cpu_en) begin
            r_is_write <= 1'b0;
        end else if (w_wb_hit) begin
            r_is_write <= 1'b1;
            r_out      <= '{rd: i_wb_rd, data: i_wb_data};
        end else if (w_pop) begin
            r_is_write <= 1'b1;
            r_out      <= w_head;
        end else begin
            r_is_write <= 1'b0;
        end
    end

    assign w_busy[0] = 1'b0;
    for (genvar g = 1; g < NREGS; g++) begin : g_busy
        regs_busy_bit u_bit (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_set  (i_cpu_en && i_mc_issue && (i_mc_issue_rd == REGS_WIDTH'(g))),
            .i_clr  (w_pop && (w_head.rd == REGS_WIDTH'(g))),
            .o_busy (w_busy[g])
        );
    end

    assign o_rs1_busy      = w_busy[i_rs1_address];
    assign o_rs2_busy      = w_busy[i_rs2_address];
    assign o_is_write_regs = r_is_write;
    assign o_write_address = r_out.rd;
    assign o_write_data    = r_out.data;
    assign o_pending       = r_cnt;
endmodule

// File: tb/tb_regs_write_port.sv
// Directed bench for regs_write_port: reset, WB path, scoreboard, priority,
// full/drain, wrap ordering, enable freeze and reset mid-operation.

module tb_regs_write_port;
    logic        clk = 1'b0;
    logic        rst, cpu_en;
    logic        wb_valid, mc_issue, mc_valid;
    logic [4:0]  wb_rd, mc_issue_rd, mc_rd, rs1_address, rs2_address;
    logic [31:0] wb_data, mc_data;
    logic        mc_ready, rs1_busy, rs2_busy, is_write_regs;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [2:0]  pending;

    int vec = 0;
    int err = 0;

    regs_write_port #(.DATA_WIDTH(32), .REGS_WIDTH(5), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_cpu_en(cpu_en),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_mc_issue(mc_issue), .i_mc_issue_rd(mc_issue_rd),
        .i_mc_valid(mc_valid), .i_mc_rd(mc_rd), .i_mc_data(mc_data),
        .o_mc_ready(mc_ready),
        .i_rs1_address(rs1_address), .i_rs2_address(rs2_address),
        .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
        .o_is_write_regs(is_write_regs), .o_write_address(write_address),
        .o_write_data(write_data), .o_pending(pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mc_issue = 0; mc_issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
    endtask

    task automatic test_reset();
        idle();
        cpu_en = 1; rst = 0;
        mc_valid = 1; mc_rd = 3; mc_data = 32'h33;
        wb_valid = 1; wb_rd = 2; wb_data = 32'h22;
        mc_issue = 1; mc_issue_rd = 3;
        step(); step();
        vec++; if (mc_ready !== 1'b0) begin err++; $display("FAIL reset_mc_ready: got %b want 0", mc_ready); end
        vec++; if (is_write_regs !== 1'b0) begin err++; $display("FAIL reset_is_write: got %b want 0", is_write_regs); end
        vec++; if (pending !== 3'd0) begin err++; $display("FAIL reset_pending: got %0d want 0", pending); end
        vec++; if (write_address !== 5'd0 || write_data !== 32'd0) begin err++; $display("FAIL reset_out: got %0d/%h want 0/0", write_address, write_data); end
        for (int a = 0; a < 32; a++) begin
            rs1_address = 5'(a); #1;
            vec++; if (rs1_busy !== 1'b0) begin err++; $display("FAIL reset_busy x%0d: got %b want 0", a, rs1_busy); end
        end
        idle(); rst = 1;
        step();
    endtask

    task automatic test_pipeline();
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        step();
        vec++; if (is_write_regs !== 1'b1 || write_address !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            err++; $display("FAIL wb_write: got %b/%0d/%h want 1/5/deadbeef", is_write_regs, write_address, write_data); end
        wb_rd = 0; wb_data = 32'h1;
        step();
        vec++; if (is_write_regs !== 1'b0) begin err++; $display("FAIL wb_x0: got %b want 0", is_write_regs); end
        vec++; if (write_address !== 5'd5 || write_data !== 32'hDEADBEEF) begin err++; $display("FAIL wb_hold: got %0d/%h want 5/deadbeef", write_address, write_data); end
        idle();
        mc_valid = 1; mc_rd = 0; mc_data = 32'h77;
        #1;
        vec++; if (mc_ready !== 1'b1) begin err++; $display("FAIL mc_x0_ready: got %b want 1", mc_ready); end
        step();
        idle();
        vec++; if (pending !== 3'd0) begin err++; $display("FAIL mc_x0_drop: got %0d want 0", pending); end
        step();
        vec++; if (is_write_regs !== 1'b0) begin err++; $display("FAIL mc_x0_nowrite: got %b want 0", is_write_regs); end
    endtask

    task automatic test_scoreboard();
        mc_issue = 1; mc_issue_rd = 7;
        step();
        mc_issue = 0;
        rs1_address = 7; rs2_address = 7; #1;
        vec++; if (rs1_busy !== 1'b1) begin err++; $display("FAIL sb_set_rs1: got %b want 1", rs1_busy); end
        vec++; if (rs2_busy !== 1'b1) begin err++; $display("FAIL sb_set_rs2: got %b want 1", rs2_busy); end
        rs2_address = 6; #1;
        vec++; if (rs2_busy !== 1'b0) begin err++; $display("FAIL sb_other: got %b want 0", rs2_busy); end
        mc_valid = 1; mc_rd = 7; mc_data = 32'h1234;
        step();
        mc_valid = 0;
        vec++; if (pending !== 3'd1 || rs1_busy !== 1'b1) begin err++; $display("FAIL sb_queued: got %0d/%b want 1/1", pending, rs1_busy); end
        step();
        vec++; if (is_write_regs !== 1'b1 || write_address !== 5'd7 || write_data !== 32'h1234) begin
            err++; $display("FAIL sb_drain: got %b/%0d/%h want 1/7/1234", is_write_regs, write_address, write_data); end
        vec++; if (rs1_busy !== 1'b0 || pending !== 3'd0) begin err++; $display("FAIL sb_clear: got %b/%0d want 0/0", rs1_busy, pending); end
        idle();
    endtask

    task automatic test_priority_full();
        wb_valid = 1; wb_rd = 10;
        for (int i = 1; i <= 4; i++) begin
            wb_data = 32'hA00 + 32'(i);
            mc_valid = 1; mc_rd = 5'(i); mc_data = 32'd100 + 32'(i);
            step();
            vec++; if (is_write_regs !== 1'b1 || write_address !== 5'd10 || write_data !== 32'hA00 + 32'(i)) begin
                err++; $display("FAIL prio_wb%0d: got %b/%0d/%h want 1/10/%h", i, is_write_regs, write_address, write_data, 32'hA00 + 32'(i)); end
        end
        mc_rd = 9; mc_data = 32'd999; #1;
        vec++; if (pending !== 3'd4 || mc_ready !== 1'b0) begin err++; $display("FAIL full: got %0d/%b want 4/0", pending, mc_ready); end
        step();
        vec++; if (pending !== 3'd4) begin err++; $display("FAIL full_hold: got %0d want 4", pending); end
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            vec++; if (is_write_regs !== 1'b1 || write_address !== 5'(i) || write_data !== 32'd100 + 32'(i)) begin
                err++; $display("FAIL drain%0d: got %b/%0d/%0d want 1/%0d/%0d", i, is_write_regs, write_address, write_data, i, 100 + i); end
            vec++; if (pending !== 3'(4 - i) || mc_ready !== 1'b1) begin err++; $display("FAIL drain_cnt%0d: got %0d/%b want %0d/1", i, pending, mc_ready, 4 - i); end
        end
        step();
        vec++; if (is_write_regs !== 1'b0) begin err++; $display("FAIL drain_done: got %b want 0", is_write_regs); end
    endtask

    task automatic test_simul_wrap();
        logic [4:0] q[$];
        wb_valid = 1; wb_rd = 20; wb_data = 32'h20;
        for (int i = 11; i <= 12; i++) begin
            mc_valid = 1; mc_rd = 5'(i); mc_data = 32'h500 + 32'(i);
            q.push_back(5'(i));
            step();
        end
        wb_valid = 0;
        for (int k = 0; k < 10; k++) begin
            logic [4:0] e;
            mc_rd = 5'(13 + k); mc_data = 32'h500 + 32'(13 + k);
            q.push_back(5'(13 + k));
            e = q.pop_front();
            step();
            vec++; if (is_write_regs !== 1'b1 || write_address !== e || write_data !== 32'h500 + 32'(e)) begin
                err++; $display("FAIL wrap%0d: got %b/%0d/%h want 1/%0d/%h", k, is_write_regs, write_address, write_data, e, 32'h500 + 32'(e)); end
            vec++; if (pending !== 3'd2) begin err++; $display("FAIL wrap_cnt%0d: got %0d want 2", k, pending); end
        end
        idle();
    endtask

    task automatic test_cpu_en();
        // FIFO holds x21,x22 from the wrap test; hold drain off with WB while tagging x25 busy
        wb_valid = 1; wb_rd = 30; wb_data = 32'h30;
        mc_issue = 1; mc_issue_rd = 25;
        step();
        idle();
        cpu_en = 0;
        mc_valid = 1; mc_rd = 5; mc_issue = 1; mc_issue_rd = 26;
        rs1_address = 25; rs2_address = 26; #1;
        vec++; if (mc_ready !== 1'b0) begin err++; $display("FAIL en_ready: got %b want 0", mc_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            vec++; if (is_write_regs !== 1'b0 || pending !== 3'd2) begin err++; $display("FAIL en_freeze%0d: got %b/%0d want 0/2", c, is_write_regs, pending); end
            vec++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin err++; $display("FAIL en_busy%0d: got %b/%b want 1/0", c, rs1_busy, rs2_busy); end
        end
        idle(); cpu_en = 1;
        step();
        vec++; if (is_write_regs !== 1'b1 || write_address !== 5'd21 || pending !== 3'd1) begin err++; $display("FAIL en_resume1: got %b/%0d/%0d want 1/21/1", is_write_regs, write_address, pending); end
        step();
        vec++; if (is_write_regs !== 1'b1 || write_address !== 5'd22 || pending !== 3'd0) begin err++; $display("FAIL en_resume2: got %b/%0d/%0d want 1/22/0", is_write_regs, write_address, pending); end
        // Same-cycle set and clear of x8
        wb_valid = 1; wb_rd = 30; mc_valid = 1; mc_rd = 8; mc_data = 32'h88;
        step();
        idle(); mc_issue = 1; mc_issue_rd = 8;
        step();
        idle(); rs1_address = 8; #1;
        vec++; if (is_write_regs !== 1'b1 || write_address !== 5'd8 || write_data !== 32'h88) begin err++; $display("FAIL setclr_write: got %b/%0d/%h want 1/8/88", is_write_regs, write_address, write_data); end
        vec++; if (rs1_busy !== 1'b1) begin err++; $display("FAIL setclr_busy: got %b want 1", rs1_busy); end
    endtask

    task automatic test_reset_mid();
        wb_valid = 1; wb_rd = 30; mc_valid = 1; mc_rd = 14; mc_data = 32'h14;
        mc_issue = 1; mc_issue_rd = 14;
        step();
        idle(); rst = 0;
        step();
        rst = 1; rs1_address = 14; rs2_address = 8; #1;
        vec++; if (pending !== 3'd0 || is_write_regs !== 1'b0) begin err++; $display("FAIL rstmid_state: got %0d/%b want 0/0", pending, is_write_regs); end
        vec++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin err++; $display("FAIL rstmid_busy: got %b/%b want 0/0", rs1_busy, rs2_busy); end
        step();
        vec++; if (is_write_regs !== 1'b0) begin err++; $display("FAIL rstmid_nowrite: got %b want 0", is_write_regs); end
    endtask

    initial begin
        rst = 0; cpu_en = 1; rs1_address = 0; rs2_address = 0;
        idle();
        test_reset();
        test_pipeline();
        test_scoreboard();
        test_priority_full();
        test_simul_wrap();
        test_cpu_en();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
